fft_seq_ctrl: RTL

Sequencer for the iterative in-place radix-2 DIT FFT datapath. It drives a single butterfly unit and the shared sample RAM through four phases:
- load N samples into RAM in bit-reversed order;
- issue LOG2_N stages of N/2 butterflies each, with twiddle indices;
- drain the butterfly pipeline between stages;
- stream results out in natural order.
The block generates control and addresses only; sample data never passes through it.

---
 rtl/fft_seq_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an iterative in-place radix-2 DIT FFT: load (bit-reversed), compute, drain, unload.
// Latency: every control output is registered except ld_we. Compute phase takes LOG2_N*(N_POINTS/2+BF_LAT) cycles.
// Backpressure: in_valid gaps hold the load counter. out_ready low holds out_* stable. Compute has no stall.
//
// Ports:
//   clk, rst (async active-low)     : clock and reset
//   start / busy / done             : transform kick-off, activity flag, one-cycle completion pulse
//   in_valid / in_ready / ld_we / ld_addr : sample load handshake and bit-reversed RAM write address
//   bf_valid / bf_addr_a / bf_addr_b / bf_tw_idx / bf_stage : butterfly issue
//   out_valid / out_ready / out_addr / out_last : natural-order readout handshake
module fft_seq_ctrl #(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6,
  parameter int BF_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ld_we,
  output logic [LOG2_N-1:0] ld_addr,
  output logic              bf_valid,
  output logic [LOG2_N-1:0] bf_addr_a,
  output logic [LOG2_N-1:0] bf_addr_b,
  output logic [LOG2_N-2:0] bf_tw_idx,
  output logic [LOG2_N-1:0] bf_stage,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG2_N-1:0] out_addr,
  output logic              out_last
);

  localparam int AW = LOG2_N;
  localparam int KW = LOG2_N - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [AW-1:0] CNT_LAST   = AW'(N_POINTS - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N_POINTS / 2 - 1);
  localparam logic [AW-1:0] STAGE_LAST = AW'(LOG2_N - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;

  state_t        state;
  logic [AW-1:0] cnt;    // load counter
  logic [KW-1:0] k;      // butterfly index within the current stage
  logic [DW-1:0] dcnt;   // drain cycle counter

  logic [KW-1:0] nk;
  logic [AW-1:0] ns;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] b_nxt;
  logic [KW-1:0] tw_nxt;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  function automatic logic [AW-1:0] half_of(input logic [AW-1:0] s);
    return AW'(1) << s;
  endfunction

  // Upper operand: insert a zero at bit position s of k.
  function automatic logic [AW-1:0] addr_a(input logic [KW-1:0] kk, input logic [AW-1:0] s);
    logic [AW-1:0] kx;
    logic [AW-1:0] mask;
    kx   = {1'b0, kk};
    mask = half_of(s) - AW'(1);
    return ((kx >> s) << (s + AW'(1))) | (kx & mask);
  endfunction

  function automatic logic [KW-1:0] tw_of(input logic [KW-1:0] kk, input logic [AW-1:0] s);
    logic [AW-1:0] kx;
    logic [AW-1:0] t;
    kx = {1'b0, kk};
    t  = (kx & (half_of(s) - AW'(1))) << (STAGE_LAST - s);
    return t[KW-1:0];
  endfunction

  // Parameters of the next butterfly to issue: first of stage 0 out of LOAD,
  // next k within COMPUTE, first of the following stage out of DRAIN.
  always_comb begin
    nk = '0;
    ns = bf_stage;
    if (state == S_COMPUTE) nk = k + KW'(1);
    if (state == S_LOAD)    ns = '0;
    if (state == S_DRAIN)   ns = bf_stage + AW'(1);
    a_nxt  = addr_a(nk, ns);
    b_nxt  = a_nxt | half_of(ns);
    tw_nxt = tw_of(nk, ns);
  end

  assign ld_we = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      k         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      ld_addr   <= '0;
      bf_valid  <= 1'b0;
      bf_addr_a <= '0;
      bf_addr_b <= '0;
      bf_tw_idx <= '0;
      bf_stage  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            cnt      <= '0;
            ld_addr  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_we) begin
            cnt     <= cnt + AW'(1);
            ld_addr <= bitrev(cnt + AW'(1));
            if (cnt == CNT_LAST) begin
              state     <= S_COMPUTE;
              in_ready  <= 1'b0;
              bf_valid  <= 1'b1;
              k         <= nk;
              bf_stage  <= ns;
              bf_addr_a <= a_nxt;
              bf_addr_b <= b_nxt;
              bf_tw_idx <= tw_nxt;
            end
          end
        end
        S_COMPUTE: begin
          if (k == K_LAST) begin
            state    <= S_DRAIN;
            bf_valid <= 1'b0;
            dcnt     <= '0;
          end else begin
            k         <= nk;
            bf_addr_a <= a_nxt;
            bf_addr_b <= b_nxt;
            bf_tw_idx <= tw_nxt;
          end
        end
        S_DRAIN: begin
          // Hold off issue until the last write of this stage has landed in RAM.
          if (dcnt == DRAIN_LAST) begin
            if (bf_stage == STAGE_LAST) begin
              state     <= S_UNLOAD;
              out_valid <= 1'b1;
              out_addr  <= '0;
              out_last  <= 1'b0;
            end else begin
              state     <= S_COMPUTE;
              bf_valid  <= 1'b1;
              k         <= nk;
              bf_stage  <= ns;
              bf_addr_a <= a_nxt;
              bf_addr_b <= b_nxt;
              bf_tw_idx <= tw_nxt;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_addr <= out_addr + AW'(1);
              out_last <= (out_addr + AW'(1)) == CNT_LAST;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
